// File: rtl/hqm_rcfwl_gclk_clken_pkg.sv
// Shared types and defaults for the usync-driven clock-enable generator.
package hqm_rcfwl_gclk_clken_pkg;

  localparam int RATIO_WIDTH_DFLT   = 4;
  localparam int LOCK_COUNT_DFLT    = 2;
  localparam int ERR_CNT_WIDTH_DFLT = 4;

  // good_cnt only has to reach LOCK_COUNT, whose legal maximum is 15.
  localparam int GOOD_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } clken_state_t;

  // The phase counter free-runs and enables are produced only in these states.
  function automatic logic is_running(input clken_state_t s);
    return (s == ST_TRACK) || (s == ST_LOCKED);
  endfunction

endpackage

// File: rtl/hqm_rcfwl_gclk_phase_cnt.sv
// Wrap-at-ratio phase counter with synchronous clear and end-of-period flag.
module hqm_rcfwl_gclk_phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  input  logic [W-1:0] ratio,
  output logic [W-1:0] phase,
  output logic         last
);

  // last marks the final fast cycle of a slow period; ratio is never 0 here.
  assign last = (phase == (ratio - W'(1)));

  // Clear has priority so a realignment always lands on phase 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (adv) begin
      phase <= last ? '0 : phase + W'(1);
    end
  end

endmodule

// File: rtl/hqm_rcfwl_gclk_usync_clken_gen.sv
// Turns a ratio usync pulse stream on the x12 grid clock into a phase-aligned
// divided clock enable, with lock tracking and sticky misalignment reporting.
module hqm_rcfwl_gclk_usync_clken_gen
  import hqm_rcfwl_gclk_clken_pkg::*;
#(
  parameter int RATIO_WIDTH   = RATIO_WIDTH_DFLT,
  parameter int LOCK_COUNT    = LOCK_COUNT_DFLT,
  parameter int ERR_CNT_WIDTH = ERR_CNT_WIDTH_DFLT
) (
  input  logic                     clk_free_in,
  input  logic                     reset_in,
  input  logic                     enable_in,
  input  logic                     usync_in,
  input  logic [RATIO_WIDTH-1:0]   ratio_in,
  input  logic                     err_clr_in,
  output logic                     clk_en_out,
  output logic                     div_reset_out,
  output logic [RATIO_WIDTH-1:0]   phase_out,
  output logic                     locked_out,
  output logic                     sync_err_out,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_out
);

  localparam logic [GOOD_CNT_WIDTH-1:0] LOCK_CNT_V = GOOD_CNT_WIDTH'(LOCK_COUNT);

  clken_state_t              state;
  logic                      usync_q;
  logic [RATIO_WIDTH-1:0]    ratio_q;
  logic [RATIO_WIDTH-1:0]    ratio_eff;
  logic [GOOD_CNT_WIDTH-1:0] good_cnt;
  logic [GOOD_CNT_WIDTH-1:0] good_inc;
  logic                      div_reset_q;
  logic                      sync_err_q;
  logic [ERR_CNT_WIDTH-1:0]  err_cnt_q;
  logic [RATIO_WIDTH-1:0]    phase;
  logic                      last;
  logic                      running;
  logic                      aligned;
  logic                      misalign;
  logic                      cnt_clr;

  assign running   = is_running(state);
  assign aligned   = enable_in && running && usync_q && last;
  assign misalign  = enable_in && running && usync_q && !last;
  assign ratio_eff = (ratio_in == '0) ? RATIO_WIDTH'(1) : ratio_in;
  assign good_inc  = (good_cnt >= LOCK_CNT_V) ? LOCK_CNT_V : good_cnt + GOOD_CNT_WIDTH'(1);

  // Phase sits at 0 outside TRACK/LOCKED so acquisition starts a fresh period.
  assign cnt_clr = !enable_in || !running || misalign;

  hqm_rcfwl_gclk_phase_cnt #(
    .W(RATIO_WIDTH)
  ) u_phase_cnt (
    .clk   (clk_free_in),
    .rst   (reset_in),
    .clr   (cnt_clr),
    .adv   (1'b1),
    .ratio (ratio_q),
    .phase (phase),
    .last  (last)
  );

  // Single retiming flop on usync; every decision below looks at usync_q only.
  always_ff @(posedge clk_free_in or posedge reset_in) begin
    if (reset_in) usync_q <= 1'b0;
    else          usync_q <= usync_in;
  end

  // Acquisition / tracking FSM with lock qualification and realign pulse.
  always_ff @(posedge clk_free_in or posedge reset_in) begin
    if (reset_in) begin
      state       <= ST_IDLE;
      ratio_q     <= RATIO_WIDTH'(1);
      good_cnt    <= '0;
      div_reset_q <= 1'b0;
    end else begin
      div_reset_q <= 1'b0;
      if (!enable_in) begin
        state    <= ST_IDLE;
        good_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_ACQ;
          ST_ACQ: begin
            if (usync_q) begin
              ratio_q     <= ratio_eff;
              good_cnt    <= GOOD_CNT_WIDTH'(1);
              div_reset_q <= 1'b1;
              state       <= (LOCK_COUNT == 1) ? ST_LOCKED : ST_TRACK;
            end
          end
          default: begin
            if (aligned) begin
              good_cnt <= good_inc;
              if (good_inc == LOCK_CNT_V) state <= ST_LOCKED;
            end else if (misalign) begin
              good_cnt    <= GOOD_CNT_WIDTH'(1);
              div_reset_q <= 1'b1;
              state       <= ST_TRACK;
            end
          end
        endcase
      end
    end
  end

  // Sticky error flag and saturating count; a coincident misalignment beats clear.
  always_ff @(posedge clk_free_in or posedge reset_in) begin
    if (reset_in) begin
      sync_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else if (misalign) begin
      sync_err_q <= 1'b1;
      if (err_clr_in)          err_cnt_q <= ERR_CNT_WIDTH'(1);
      else if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
    end else if (err_clr_in) begin
      sync_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end
  end

  assign clk_en_out    = running && (phase == '0);
  assign div_reset_out = div_reset_q;
  assign phase_out     = phase;
  assign locked_out    = (state == ST_LOCKED);
  assign sync_err_out  = sync_err_q;
  assign err_cnt_out   = err_cnt_q;

endmodule
